// File: rtl/ram_refresh_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_refresh_sched_if
//  Description : Handshake bundle between the refresh scheduler and the RAM
//                sequencer.
//                  en           - refresh timing enable (post-init gate)
//                  ref_ack      - 1-cycle pulse, sequencer entered refresh RAS
//                  ref_req      - a refresh is owed
//                  ref_urg      - refresh overdue
//                  ref_debt     - current owed-refresh count
//                  ref_overflow - sticky, a due event hit a saturated debt
//                master = scheduler side, slave = sequencer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface ram_refresh_sched_if #(
    parameter int DEBTW = 3
);
    logic             en;
    logic             ref_ack;
    logic             ref_req;
    logic             ref_urg;
    logic [DEBTW-1:0] ref_debt;
    logic             ref_overflow;

    modport master (
        input  en,
        input  ref_ack,
        output ref_req,
        output ref_urg,
        output ref_debt,
        output ref_overflow
    );

    modport slave (
        output en,
        output ref_ack,
        input  ref_req,
        input  ref_urg,
        input  ref_debt,
        input  ref_overflow
    );
endinterface
`default_nettype wire

// File: rtl/ram_refresh_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ram_refresh_sched
//  Description : DRAM refresh scheduler. A prescaler and interval counter
//                produce a periodic due event; owed refreshes accumulate in a
//                saturating debt counter that is retired by the sequencer's
//                refresh acknowledge. ref_req/ref_urg are registered from the
//                next-state debt so they move on the same edge as ref_debt.
//  Ports       : clk  - system clock
//                rst  - asynchronous reset, active-high
//                bus  - ram_refresh_sched_if.master (en, ref_ack in;
//                       ref_req, ref_urg, ref_debt, ref_overflow out)
//  Options     : REF_AGE_URG_EN - when defined, an age counter also raises
//                ref_urg once a request has waited URG_AGE cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_refresh_sched #(
    parameter int PRESCALE   = 8,
    parameter int INTERVAL   = 48,
    parameter int DEBT_MAX   = 7,
    parameter int DEBTW      = 3,
    parameter int URG_THRESH = 2,
    parameter int URG_AGE    = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_refresh_sched_if.master  bus
);

    localparam int PREW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int INTW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    localparam logic [PREW-1:0]  PRE_LAST = PREW'(PRESCALE - 1);
    localparam logic [INTW-1:0]  INT_LAST = INTW'(INTERVAL - 1);
    localparam logic [DEBTW-1:0] DEBT_SAT = DEBTW'(DEBT_MAX);
    localparam logic [DEBTW-1:0] DEBT_URG = DEBTW'(URG_THRESH);

    // Elaboration-time parameter sanity checks.
    if (PRESCALE < 1 || INTERVAL < 1) begin : g_chk_timing
        $error("ram_refresh_sched: PRESCALE and INTERVAL must be >= 1");
    end
    if (DEBT_MAX < 1 || DEBT_MAX > (2**DEBTW - 1)) begin : g_chk_debt
        $error("ram_refresh_sched: DEBT_MAX out of range for DEBTW");
    end
    if (URG_THRESH < 1 || URG_THRESH > DEBT_MAX) begin : g_chk_thresh
        $error("ram_refresh_sched: URG_THRESH must be in 1..DEBT_MAX");
    end
    if (URG_AGE < 1) begin : g_chk_age
        $error("ram_refresh_sched: URG_AGE must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_URG  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Tick / due timing. Both counters freeze (hold value) while en=0 so an
    // interrupted interval resumes where it left off.
    // ------------------------------------------------------------------------
    logic [PREW-1:0] r_pre;
    logic [INTW-1:0] r_int;
    logic            w_tick;
    logic            w_due;

    assign w_tick = bus.en && (r_pre == PRE_LAST);
    assign w_due  = w_tick && (r_int == INT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_int <= '0;
        end else if (bus.en) begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_int <= (r_int == INT_LAST) ? '0 : r_int + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Debt counter and state. The state is a classification of the debt, so
    // registering it from debt_next makes ref_req/ref_urg change on the same
    // edge as ref_debt.
    // ------------------------------------------------------------------------
    logic [DEBTW-1:0] r_debt;
    logic [DEBTW-1:0] w_debt_next;
    logic             w_ovf_set;
    logic             r_overflow;
    state_t           r_state;
    state_t           w_state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_debt     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_debt     <= w_debt_next;
            r_overflow <= r_overflow | w_ovf_set;
        end
    end

    always_comb begin
        w_debt_next  = r_debt;
        w_ovf_set    = 1'b0;
        w_state_next = r_state;

        unique case ({w_due, bus.ref_ack})
            2'b10: begin
                if (r_debt == DEBT_SAT) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_debt_next = r_debt + 1'b1;
                end
            end
            2'b01: begin
                // An acknowledge with nothing owed is ignored.
                if (r_debt != '0) begin
                    w_debt_next = r_debt - 1'b1;
                end
            end
            // Due and ack together cancel: no change, no overflow flag.
            default: w_debt_next = r_debt;
        endcase

        if (w_debt_next == '0) begin
            w_state_next = ST_IDLE;
        end else if (w_debt_next >= DEBT_URG) begin
            w_state_next = ST_URG;
        end else begin
            w_state_next = ST_PEND;
        end
    end

    assign bus.ref_req      = (r_state != ST_IDLE);
    assign bus.ref_debt     = r_debt;
    assign bus.ref_overflow = r_overflow;

`ifdef REF_AGE_URG_EN
    // ------------------------------------------------------------------------
    // Request age. Counts every cycle that debt is owed, saturating at
    // URG_AGE-1; the urgent flag is registered from the saturated age and is
    // suppressed on the edge that retires or empties the debt.
    // ------------------------------------------------------------------------
    localparam int              AGEW     = (URG_AGE > 1) ? $clog2(URG_AGE) : 1;
    localparam logic [AGEW-1:0] AGE_LAST = AGEW'(URG_AGE - 1);

    logic [AGEW-1:0] r_age;
    logic [AGEW-1:0] w_age_next;
    logic            r_age_urg;
    logic            w_age_urg_next;

    always_comb begin
        w_age_next = r_age;
        if (bus.ref_ack || (w_debt_next == '0)) begin
            w_age_next = '0;
        end else if ((r_debt != '0) && (r_age != AGE_LAST)) begin
            w_age_next = r_age + 1'b1;
        end
        w_age_urg_next = (r_age == AGE_LAST) && !bus.ref_ack && (w_debt_next != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age     <= '0;
            r_age_urg <= 1'b0;
        end else begin
            r_age     <= w_age_next;
            r_age_urg <= w_age_urg_next;
        end
    end

    assign bus.ref_urg = (r_state == ST_URG) || r_age_urg;
`else
    assign bus.ref_urg = (r_state == ST_URG);
`endif

endmodule
`default_nettype wire
